// File: rtl/pipe_ctrl_chain_pkg.sv
// rtl/pipe_ctrl_chain_pkg.sv - shared pipeline defaults, NOP word and stage actions
package pipe_ctrl_chain_pkg;

    localparam int unsigned PIPE_WIDTH  = 17;
    localparam int unsigned PIPE_STAGES = 3;
    localparam int unsigned PIPE_CNT_W  = 8;

    // All-zero control word: every control bit deasserted.
    localparam logic [31:0] NOP_WORD = 32'h0;

    typedef enum logic [1:0] {
        ACT_LOAD  = 2'd0,
        ACT_HOLD  = 2'd1,
        ACT_FLUSH = 2'd2
    } stage_act_e;

endpackage

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - one control word + valid register with flush/hold/load
module pipe_stage_reg
    import pipe_ctrl_chain_pkg::*;
#(
    parameter int unsigned WIDTH = PIPE_WIDTH
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             hold_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] word_o,
    output logic             valid_o
);

    stage_act_e       act;
    logic [WIDTH-1:0] word_d,  word_q;
    logic             valid_d, valid_q;

    always_comb begin
        act     = ACT_LOAD;
        word_d  = word_q;
        valid_d = valid_q;
        if (flush_i) begin
            act = ACT_FLUSH;
        end else if (hold_i) begin
            act = ACT_HOLD;
        end
        case (act)
            ACT_FLUSH: begin
                word_d  = WIDTH'(NOP_WORD);
                valid_d = 1'b0;
            end
            ACT_LOAD: begin
                // Mask the word so an invalid slot never carries stale bits.
                word_d  = valid_i ? word_i : WIDTH'(NOP_WORD);
                valid_d = valid_i;
            end
            default: begin
                word_d  = word_q;
                valid_d = valid_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word_o  = word_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pipe_ctrl_chain.sv
// rtl/pipe_ctrl_chain.sv - control-signal pipeline with bubble/freeze/flush and counters
module pipe_ctrl_chain
    import pipe_ctrl_chain_pkg::*;
#(
    parameter int unsigned WIDTH  = PIPE_WIDTH,
    parameter int unsigned STAGES = PIPE_STAGES,
    parameter int unsigned CNT_W  = PIPE_CNT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        ctrl_in,
    input  logic                    ctrl_valid_in,
    input  logic                    bubble,
    input  logic                    freeze,
    input  logic [STAGES-1:0]       flush,
    output logic [STAGES*WIDTH-1:0] stage_ctrl,
    output logic [STAGES-1:0]       stage_valid,
    output logic [WIDTH-1:0]        ctrl_out,
    output logic                    valid_out,
    output logic [CNT_W-1:0]        bubble_count,
    output logic [15:0]             retire_count
);

    logic             accept;
    logic             s0_nop;
    logic [WIDTH-1:0] word_w [STAGES];
    logic [CNT_W-1:0] bubble_d, bubble_q;
    logic [15:0]      retire_d, retire_q;

    assign accept = ctrl_valid_in & ~bubble;
    // A stage-0 flush also delivers a NOP into stage 0, so it counts as a bubble.
    assign s0_nop = flush[0] | ~accept;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic [WIDTH-1:0] in_word;
        logic             in_valid;

        if (i == 0) begin : g_head
            assign in_word  = ctrl_in;
            assign in_valid = accept;
        end else begin : g_body
            assign in_word  = word_w[i-1];
            assign in_valid = stage_valid[i-1];
        end

        pipe_stage_reg #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk     (clk),
            .reset_i (reset),
            .flush_i (flush[i]),
            .hold_i  (freeze),
            .word_i  (in_word),
            .valid_i (in_valid),
            .word_o  (word_w[i]),
            .valid_o (stage_valid[i])
        );

        assign stage_ctrl[i*WIDTH +: WIDTH] = word_w[i];
    end

    assign ctrl_out  = word_w[STAGES-1];
    assign valid_out = stage_valid[STAGES-1];

    always_comb begin
        bubble_d = bubble_q;
        retire_d = retire_q;
        if (!freeze) begin
            if (s0_nop && (bubble_q != {CNT_W{1'b1}})) begin
                bubble_d = bubble_q + CNT_W'(1);
            end
            if (valid_out && !flush[STAGES-1]) begin
                retire_d = retire_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_q <= '0;
            retire_q <= '0;
        end else begin
            bubble_q <= bubble_d;
            retire_q <= retire_d;
        end
    end

    assign bubble_count = bubble_q;
    assign retire_count = retire_q;

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// tb/tb_pipe_ctrl_chain.sv - directed self-checking bench for pipe_ctrl_chain
module tb_pipe_ctrl_chain;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [16:0] ctrl_in = '0;
    logic        ctrl_valid_in = 1'b0;
    logic        bubble = 1'b0;
    logic        freeze = 1'b0;
    logic [2:0]  flush = '0;

    logic [50:0] stage_ctrl;
    logic [2:0]  stage_valid;
    logic [16:0] ctrl_out;
    logic        valid_out;
    logic [7:0]  bubble_count;
    logic [15:0] retire_count;

    logic [16:0] stage_ctrl1;
    logic [0:0]  stage_valid1;
    logic [16:0] ctrl_out1;
    logic        valid_out1;
    logic [7:0]  bubble_count1;
    logic [15:0] retire_count1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_ctrl_chain dut (
        .clk           (clk),
        .reset         (reset),
        .ctrl_in       (ctrl_in),
        .ctrl_valid_in (ctrl_valid_in),
        .bubble        (bubble),
        .freeze        (freeze),
        .flush         (flush),
        .stage_ctrl    (stage_ctrl),
        .stage_valid   (stage_valid),
        .ctrl_out      (ctrl_out),
        .valid_out     (valid_out),
        .bubble_count  (bubble_count),
        .retire_count  (retire_count)
    );

    pipe_ctrl_chain #(.STAGES(1)) dut1 (
        .clk           (clk),
        .reset         (reset),
        .ctrl_in       (ctrl_in),
        .ctrl_valid_in (ctrl_valid_in),
        .bubble        (bubble),
        .freeze        (freeze),
        .flush         (flush[0:0]),
        .stage_ctrl    (stage_ctrl1),
        .stage_valid   (stage_valid1),
        .ctrl_out      (ctrl_out1),
        .valid_out     (valid_out1),
        .bubble_count  (bubble_count1),
        .retire_count  (retire_count1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [16:0] w, input logic v, input logic b,
                         input logic f, input logic [2:0] fl);
        ctrl_in       = w;
        ctrl_valid_in = v;
        bubble        = b;
        freeze        = f;
        flush         = fl;
    endtask

    task automatic pulse_reset();
        drive(17'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_stage_ctrl", 64'(stage_ctrl), 64'h0);
        chk("rst_stage_valid", 64'(stage_valid), 64'h0);
        chk("rst_valid_out", 64'(valid_out), 64'h0);
        chk("rst_bubble", 64'(bubble_count), 64'h0);
        chk("rst_retire", 64'(retire_count), 64'h0);
        reset = 1'b0;

        // Single word latency
        drive(17'h1ABCD, 1'b1, 1'b0, 1'b0, 3'b000);
        step();
        drive(17'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        chk("lat_s0", 64'(stage_ctrl), 64'({17'h0, 17'h0, 17'h1ABCD}));
        chk("lat_valid_out_e0", 64'(valid_out), 64'h0);
        chk("s1_ctrl_out", 64'(ctrl_out1), 64'h1ABCD);
        chk("s1_valid_out", 64'(valid_out1), 64'h1);
        step();
        chk("lat_valid_out_e1", 64'(valid_out), 64'h0);
        chk("s1_valid_drop", 64'(valid_out1), 64'h0);
        step();
        chk("lat_ctrl_out", 64'(ctrl_out), 64'h1ABCD);
        chk("lat_valid_out", 64'(valid_out), 64'h1);
        step();
        chk("lat_retire", 64'(retire_count), 64'h1);
        chk("lat_valid_gone", 64'(valid_out), 64'h0);
        chk("lat_bubble", 64'(bubble_count), 64'h3);

        // Stream with bubble on the second cycle
        pulse_reset();
        drive(17'h00001, 1'b1, 1'b0, 1'b0, 3'b000);
        step();
        drive(17'h00002, 1'b1, 1'b1, 1'b0, 3'b000);
        step();
        drive(17'h00003, 1'b1, 1'b0, 1'b0, 3'b000);
        step();
        drive(17'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        chk("bub_stages", 64'(stage_ctrl), 64'({17'h1, 17'h0, 17'h3}));
        chk("bub_valids", 64'(stage_valid), 64'h5);
        chk("bub_out1", 64'(ctrl_out), 64'h1);
        chk("bub_count", 64'(bubble_count), 64'h1);
        step();
        chk("bub_out0", 64'(ctrl_out), 64'h0);
        chk("bub_out0_valid", 64'(valid_out), 64'h0);
        step();
        chk("bub_out3", 64'(ctrl_out), 64'h3);
        chk("bub_out3_valid", 64'(valid_out), 64'h1);

        // Freeze with flush of the middle stage
        pulse_reset();
        drive(17'h00001, 1'b1, 1'b0, 1'b0, 3'b000);
        step();
        drive(17'h00002, 1'b1, 1'b0, 1'b0, 3'b000);
        step();
        drive(17'h00003, 1'b1, 1'b0, 1'b0, 3'b000);
        step();
        drive(17'h0, 1'b0, 1'b1, 1'b1, 3'b010);
        step();
        drive(17'h0, 1'b0, 1'b1, 1'b1, 3'b000);
        chk("frz_flush_stages", 64'(stage_ctrl), 64'({17'h1, 17'h0, 17'h3}));
        step();
        step();
        step();
        chk("frz_stages", 64'(stage_ctrl), 64'({17'h1, 17'h0, 17'h3}));
        chk("frz_valids", 64'(stage_valid), 64'h5);
        chk("frz_bubble", 64'(bubble_count), 64'h0);
        chk("frz_retire", 64'(retire_count), 64'h0);
        drive(17'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        step();
        chk("unfrz_stages", 64'(stage_ctrl), 64'({17'h0, 17'h3, 17'h0}));
        chk("unfrz_retire", 64'(retire_count), 64'h1);
        chk("unfrz_bubble", 64'(bubble_count), 64'h1);

        // Bubble counter saturation
        pulse_reset();
        drive(17'h00055, 1'b1, 1'b1, 1'b0, 3'b000);
        for (int i = 0; i < 254; i++) step();
        chk("sat_254", 64'(bubble_count), 64'd254);
        for (int i = 0; i < 46; i++) step();
        chk("sat_255", 64'(bubble_count), 64'd255);
        chk("sat_valid", 64'(stage_valid), 64'h0);

        // Asynchronous reset mid-stream
        pulse_reset();
        drive(17'h00001, 1'b1, 1'b0, 1'b0, 3'b000);
        step();
        drive(17'h00002, 1'b1, 1'b0, 1'b0, 3'b000);
        step();
        drive(17'h00003, 1'b1, 1'b0, 1'b0, 3'b000);
        step();
        chk("full_valids", 64'(stage_valid), 64'h7);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_stage_ctrl", 64'(stage_ctrl), 64'h0);
        chk("arst_valids", 64'(stage_valid), 64'h0);
        chk("arst_out", 64'({valid_out, ctrl_out}), 64'h0);
        reset = 1'b0;
        drive(17'h0AAAA, 1'b1, 1'b0, 1'b0, 3'b000);
        step();
        drive(17'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        step();
        chk("arst_lat_e1", 64'(valid_out), 64'h0);
        step();
        chk("arst_lat_out", 64'({valid_out, ctrl_out}), 64'({1'b1, 17'h0AAAA}));
        drive(17'h00005, 1'b1, 1'b0, 1'b0, 3'b001);
        step();
        drive(17'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        chk("flush0_valid", 64'(stage_valid), 64'h0);
        chk("flush0_bubble", 64'(bubble_count), 64'h3);

        // Retire counter wrap and last-stage flush
        pulse_reset();
        drive(17'h00007, 1'b1, 1'b0, 1'b0, 3'b000);
        for (int i = 0; i < 65538; i++) step();
        chk("ret_ffff", 64'(retire_count), 64'hFFFF);
        step();
        chk("ret_wrap", 64'(retire_count), 64'h0);
        drive(17'h00007, 1'b1, 1'b0, 1'b0, 3'b100);
        step();
        drive(17'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        chk("ret_flush_hold", 64'(retire_count), 64'h0);
        chk("ret_flush_valids", 64'(stage_valid), 64'h3);
        chk("ret_bubble", 64'(bubble_count), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
